// File: rtl/msg_frame_asm.sv
// Framed message assembler: hunts for a start-of-frame word, collects a fixed
// number of payload words, optionally verifies an XOR checksum word, enforces
// an inter-word timeout and queues good packets in a small packet FIFO that the
// controller drains through a pop interface. Saturating error counters report
// link health.
module msg_frame_asm #(
    parameter int                   WORD_SIZE        = 8,
    parameter int                   WORDS_PER_PACKET = 4,
    parameter logic [WORD_SIZE-1:0] SOF_WORD         = 8'hA5,
    parameter int                   CHECKSUM_EN      = 1,
    parameter int                   TIMEOUT_CLKS     = 24000,
    parameter int                   FIFO_DEPTH       = 4,
    parameter int                   CNT_WIDTH        = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WORD_SIZE-1:0]                  data_in,
    input  logic                                  data_in_valid,
    output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
    output logic                                  data_out_avail,
    input  logic                                  data_out_req,
    output logic                                  fifo_full,
    output logic                                  busy,
    output logic [CNT_WIDTH-1:0]                  err_checksum_cnt,
    output logic [CNT_WIDTH-1:0]                  err_timeout_cnt,
    output logic [CNT_WIDTH-1:0]                  err_overflow_cnt
);

    localparam int PKT_W = WORD_SIZE * WORDS_PER_PACKET;
    localparam int IDX_W = $clog2(WORDS_PER_PACKET + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CLKS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PACKET - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CLKS - 1);
    // Write/read pointer XOR pattern when the FIFO holds FIFO_DEPTH packets:
    // wrap bits differ, address bits equal.
    localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    // Saturating increment for the error counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [WORD_SIZE-1:0]   acc;
    logic [TMR_W-1:0]       timer;
    logic [PKT_W-1:0]       pkt;

    logic [PKT_W-1:0]       pkt_next;
    logic                   word_last;
    logic                   tmr_expired;
    logic                   push_req;
    logic [PKT_W-1:0]       push_data;
    logic                   chk_err;
    logic                   tmo;

    logic [PKT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_next;
    logic [PTR_W-1:0]       rd_next;
    logic [PKT_W-1:0]       head_next;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   ovf;

    // Frame decode: which event (commit, checksum error, timeout) this cycle produces.
    always_comb begin
        pkt_next    = (pkt << WORD_SIZE) | PKT_W'(data_in);
        word_last   = (idx == LAST_IDX);
        tmr_expired = (timer == TMR_MAX);
        push_req    = 1'b0;
        push_data   = pkt_next;
        chk_err     = 1'b0;
        tmo         = 1'b0;
        case (state)
            PAYLOAD: begin
                if (data_in_valid) begin
                    if (word_last && (CHECKSUM_EN == 0)) begin
                        push_req = 1'b1;
                    end
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            CHECK: begin
                if (data_in_valid) begin
                    if (data_in == acc) begin
                        push_req  = 1'b1;
                        push_data = pkt;
                    end else begin
                        chk_err = 1'b1;
                    end
                end else if (tmr_expired) begin
                    tmo = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Frame FSM: SOF hunt, payload shift/accumulate, checksum word, timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            timer <= '0;
            pkt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in_valid && (data_in == SOF_WORD)) begin
                        idx   <= '0;
                        acc   <= '0;
                        timer <= '0;
                        state <= PAYLOAD;
                        busy  <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (data_in_valid) begin
                        pkt   <= pkt_next;
                        acc   <= acc ^ data_in;
                        timer <= '0;
                        if (word_last) begin
                            idx <= '0;
                            if (CHECKSUM_EN != 0) begin
                                state <= CHECK;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (tmo) begin
                        timer <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                CHECK: begin
                    if (data_in_valid || tmo) begin
                        timer <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO control: a push into a full FIFO only succeeds when a pop frees a slot
    // on the same edge. The head of the next cycle is bypassed from the push data
    // when the packet being written becomes the head.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = ((wr_ptr ^ rd_ptr) == FULL_XOR);
        pop     = data_out_req && !empty;
        push_ok = push_req && (!full || pop);
        ovf     = push_req && full && !pop;
        rd_next = rd_ptr + {{(PTR_W-1){1'b0}}, pop};
        wr_next = wr_ptr + {{(PTR_W-1){1'b0}}, push_ok};
        if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_next[AW-1:0]];
        end
    end

    // Packet storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers and registered head/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            data_out       <= '0;
            data_out_avail <= 1'b0;
            fifo_full      <= 1'b0;
        end else begin
            wr_ptr         <= wr_next;
            rd_ptr         <= rd_next;
            data_out       <= head_next;
            data_out_avail <= (wr_next != rd_next);
            fifo_full      <= ((wr_next ^ rd_next) == FULL_XOR);
        end
    end

    // Saturating link-health counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_checksum_cnt <= '0;
            err_timeout_cnt  <= '0;
            err_overflow_cnt <= '0;
        end else begin
            if (chk_err) err_checksum_cnt <= sat_inc(err_checksum_cnt);
            if (tmo)     err_timeout_cnt  <= sat_inc(err_timeout_cnt);
            if (ovf)     err_overflow_cnt <= sat_inc(err_overflow_cnt);
        end
    end

endmodule

// File: tb/tb_msg_frame_asm.sv
// Bench for msg_frame_asm: directed scenarios plus randomized framing traffic,
// every cycle compared against a word-list/packet-queue reference model.
`timescale 1ns/1ps
module tb_msg_frame_asm;

    localparam int WS    = 8;
    localparam int WPP   = 4;
    localparam int CSUM  = 1;
    localparam int TMO   = 100;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int PW    = WS * WPP;
    localparam logic [WS-1:0] SOF = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [WS-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          data_out_req = 1'b0;
    logic [PW-1:0] data_out;
    logic          data_out_avail;
    logic          fifo_full;
    logic          busy;
    logic [CW-1:0] err_checksum_cnt;
    logic [CW-1:0] err_timeout_cnt;
    logic [CW-1:0] err_overflow_cnt;

    msg_frame_asm #(
        .WORD_SIZE(WS), .WORDS_PER_PACKET(WPP), .SOF_WORD(SOF), .CHECKSUM_EN(CSUM),
        .TIMEOUT_CLKS(TMO), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_out(data_out), .data_out_avail(data_out_avail), .data_out_req(data_out_req),
        .fifo_full(fifo_full), .busy(busy), .err_checksum_cnt(err_checksum_cnt),
        .err_timeout_cnt(err_timeout_cnt), .err_overflow_cnt(err_overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [PW-1:0] m_q[$];
    logic [WS-1:0] m_words[$];
    bit            m_in_frame;
    int            m_idle;
    int            m_chk, m_tmo, m_ovf;

    logic [WS-1:0] tx[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_words.delete();
        m_in_frame = 0;
        m_idle = 0;
        m_chk = 0;
        m_tmo = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input logic [WS-1:0] d, input bit req);
        bit            pop;
        bit            commit;
        logic [PW-1:0] pk;
        logic [WS-1:0] x;
        int            sz;
        pop    = req && (m_q.size() != 0);
        commit = 0;
        pk     = '0;
        if (!m_in_frame) begin
            if (v && d == SOF) begin
                m_in_frame = 1;
                m_words.delete();
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            m_words.push_back(d);
            if (m_words.size() == WPP + CSUM) begin
                x = '0;
                for (int i = 0; i < WPP; i++) begin
                    pk = (pk << WS) | PW'(m_words[i]);
                    x  = x ^ m_words[i];
                end
                if (CSUM == 0 || x == m_words[WPP]) commit = 1;
                else m_chk = sat(m_chk);
                m_in_frame = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_tmo = sat(m_tmo);
                m_in_frame = 0;
            end
        end
        sz = m_q.size();
        if (pop) void'(m_q.pop_front());
        if (commit) begin
            if (sz == DEPTH && !pop) m_ovf = sat(m_ovf);
            else m_q.push_back(pk);
        end
    endtask

    task automatic compare_all();
        chk("avail", data_out_avail, m_q.size() != 0);
        chk("fifo_full", fifo_full, m_q.size() == DEPTH);
        chk("busy", busy, m_in_frame);
        chk("err_checksum", err_checksum_cnt, 64'(m_chk));
        chk("err_timeout", err_timeout_cnt, 64'(m_tmo));
        chk("err_overflow", err_overflow_cnt, 64'(m_ovf));
        if (m_q.size() != 0) chk("data_out", data_out, m_q[0]);
    endtask

    task automatic cycle(input bit v, input logic [WS-1:0] d, input bit req);
        data_in_valid = v;
        data_in       = d;
        data_out_req  = req;
        @(posedge clk);
        model_step(v, d, req);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, WS'($urandom), 1'b0);
    endtask

    task automatic send_tx();
        foreach (tx[i]) cycle(1'b1, tx[i], 1'b0);
        tx.delete();
    endtask

    task automatic add_frame(input logic [PW-1:0] p, input bit corrupt);
        logic [WS-1:0] x;
        logic [WS-1:0] w;
        x = '0;
        tx.push_back(SOF);
        for (int i = WPP - 1; i >= 0; i--) begin
            w = p[i*WS +: WS];
            tx.push_back(w);
            x = x ^ w;
        end
        tx.push_back(corrupt ? (x ^ 8'h01) : x);
    endtask

    task automatic pop_one();
        cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p5 [5];
        model_reset();
        // Power-on reset
        #3 reset = 1'b1;
        #1;
        chk("rst_avail", data_out_avail, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_data", data_out, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Good frame
        tx = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_tx();
        chk("t1_avail", data_out_avail, 1);
        chk("t1_data", data_out, 32'h11223344);
        pop_one();

        // Bad checksum then a good frame
        tx = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_tx();
        chk("t2_avail", data_out_avail, 0);
        chk("t2_chk_cnt", err_checksum_cnt, 1);
        tx = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_tx();
        chk("t2_data", data_out, 32'h01020304);
        pop_one();

        // Leading garbage and SOF as payload
        tx = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hA4};
        send_tx();
        chk("t3_data", data_out, 32'hA5000001);
        chk("t3_chk_cnt", err_checksum_cnt, 1);
        pop_one();

        // Timeout, recovery, and a word arriving in the last allowed cycle
        tx = '{8'hA5, 8'h11};
        send_tx();
        idle(TMO);
        chk("t4_tmo_cnt", err_timeout_cnt, 1);
        chk("t4_busy", busy, 0);
        add_frame(32'hDEADBEEF, 0);
        send_tx();
        chk("t4_data", data_out, 32'hDEADBEEF);
        pop_one();
        tx = '{8'hA5, 8'h11};
        send_tx();
        idle(TMO - 1);
        chk("t4_edge_busy", busy, 1);
        tx = '{8'h22, 8'h33, 8'h44, 8'h44};
        send_tx();
        chk("t4_edge_data", data_out, 32'h11223344);
        chk("t4_edge_tmo", err_timeout_cnt, 1);
        pop_one();

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) begin
            p5[i] = 32'h10203040 + 32'h01010101 * i;
            add_frame(p5[i], 0);
            send_tx();
            if (i == 3) chk("t5_full", fifo_full, 1);
        end
        chk("t5_ovf", err_overflow_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_order", data_out, p5[i]);
            pop_one();
        end
        chk("t5_empty", data_out_avail, 0);

        // Reset mid-frame
        tx = '{8'hA5, 8'h11, 8'h22};
        send_tx();
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_chk_cnt", err_checksum_cnt, 0);
        chk("t6_tmo_cnt", err_timeout_cnt, 0);
        chk("t6_ovf_cnt", err_overflow_cnt, 0);
        chk("t6_avail", data_out_avail, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tx = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_tx();
        chk("t6_data", data_out, 32'h01020304);
        pop_one();

        // Counter saturation
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            add_frame(32'h0BADF00D + i, 1);
            send_tx();
        end
        chk("sat_chk_cnt", err_checksum_cnt, (1 << CW) - 1);

        // Randomized traffic with random gaps and pops
        for (int f = 0; f < 250; f++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                tx.push_back(WS'($urandom));
            end else begin
                add_frame(PW'($urandom), kind == 1);
                if (kind == 2) begin
                    int cut;
                    cut = int'($urandom_range(1, WPP));
                    repeat (cut) void'(tx.pop_back());
                end
            end
            foreach (tx[i]) begin
                int gap;
                gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 2, TMO + 1))
                                                   : int'($urandom_range(0, 2));
                repeat (gap) cycle(1'b0, WS'($urandom), $urandom_range(0, 3) == 0);
                cycle(1'b1, tx[i], $urandom_range(0, 3) == 0);
            end
            tx.delete();
        end
        repeat (TMO + 5) cycle(1'b0, '0, 1'b1);
        chk("final_empty", data_out_avail, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
